grid_mem_rc: RTL

Parametrised dual-port grid memory for the Tetris playfield, with a built-in row-collapse engine. Port A is read/write and port B read-only, both with registered outputs. On command, the engine removes one row, shifts every row above it down by one and zero-fills the top row, so game logic can clear completed lines without issuing per-cell traffic. It sits between the game-control FSM (port A, collapse command) and the display scanner (port B).

---
 rtl/grid_pkg.sv | 19 +
 rtl/grid_rowclr_fsm.sv | 92 +++++++++
 rtl/grid_mem_rc.sv | 102 ++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants and collapse state type for the grid memory
// Purpose: default grid geometry, linear cell count and row-collapse FSM states.
// Exports: GRID_DATA_W, GRID_COLS, GRID_ROWS, GRID_ADDR_W, GRID_CELLS, clr_state_e.
package grid_pkg;

  localparam int GRID_DATA_W = 8;
  localparam int GRID_COLS   = 10;
  localparam int GRID_ROWS   = 20;
  localparam int GRID_ADDR_W = 8;
  localparam int GRID_CELLS  = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } clr_state_e;

endpackage

// File: rtl/grid_rowclr_fsm.sv
// rtl/grid_rowclr_fsm.sv - row-collapse sequencer for the grid memory
// Purpose: walks rows clr_row..1 copying each cell from the row above, then
//          zero-fills row 0, one cell per cycle.
// Ports: clk, rst_n (async, active-low); clr_start_i/clr_row_i command;
//        busy_o, done_o status; we_o, fill_o, rd_addr_o, wr_addr_o drive the array.
module grid_rowclr_fsm
  import grid_pkg::*;
#(
  parameter int COLS   = GRID_COLS,
  parameter int ROWS   = GRID_ROWS,
  parameter int ADDR_W = GRID_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start_i,
  input  logic [ADDR_W-1:0] clr_row_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              we_o,
  output logic              fill_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    we_o      = 1'b0;
    fill_o    = 1'b0;
    last_col  = (col_q == COLS_A - ONE_A);
    // Source is the same column one row up; only meaningful in SHIFT.
    rd_addr_o = (row_q - ONE_A) * COLS_A + col_q;
    wr_addr_o = row_q * COLS_A + col_q;

    unique case (state_q)
      // DONE behaves like IDLE for command acceptance so back-to-back
      // collapses lose no cycle.
      IDLE, DONE: begin
        done_o  = (state_q == DONE);
        state_d = IDLE;
        if (clr_start_i && (clr_row_i < ROWS_A)) begin
          row_d   = clr_row_i;
          col_d   = '0;
          state_d = (clr_row_i == '0) ? FILL : SHIFT;
        end
      end
      SHIFT: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
        col_d  = last_col ? '0 : col_q + ONE_A;
        if (last_col) begin
          row_d = row_q - ONE_A;
          // row_q reaches 0 here, so FILL addresses row 0 directly.
          if (row_q == ONE_A) state_d = FILL;
        end
      end
      FILL: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
        fill_o = 1'b1;
        col_d  = last_col ? '0 : col_q + ONE_A;
        if (last_col) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/grid_mem_rc.sv
// rtl/grid_mem_rc.sv - dual-port playfield memory with row-collapse engine
// Purpose: port A read/write (write-first), port B read-only (write-first vs A),
//          both registered; optional collapse engine under GRID_MEM_RC_ROWCLR_EN.
// Ports: clk, rst_n (async, active-low); addr_a/data_a/we_a -> q_a;
//        addr_b -> q_b; clr_start/clr_row -> clr_busy/clr_done.
// Macro: GRID_MEM_RC_ROWCLR_EN builds the collapse engine; otherwise plain RAM.
module grid_mem_rc
  import grid_pkg::*;
#(
  parameter int DATA_W = GRID_DATA_W,
  parameter int COLS   = GRID_COLS,
  parameter int ROWS   = GRID_ROWS,
  parameter int ADDR_W = GRID_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              we_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_row,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int            CELLS   = ROWS * COLS;
  localparam logic [ADDR_W:0] CELLS_X = (ADDR_W+1)'(CELLS);

  logic [DATA_W-1:0] mem [CELLS];

  logic              a_in, b_in, a_wr;
  logic              eng_we, eng_fill;
  logic [ADDR_W-1:0] eng_raddr, eng_waddr;
  logic [DATA_W-1:0] eng_wdata;

`ifdef GRID_MEM_RC_ROWCLR_EN
  grid_rowclr_fsm #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_rowclr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_start_i (clr_start),
    .clr_row_i   (clr_row),
    .busy_o      (clr_busy),
    .done_o      (clr_done),
    .we_o        (eng_we),
    .fill_o      (eng_fill),
    .rd_addr_o   (eng_raddr),
    .wr_addr_o   (eng_waddr)
  );
`else
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_row};
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign eng_we     = 1'b0;
  assign eng_fill   = 1'b0;
  assign eng_raddr  = '0;
  assign eng_waddr  = '0;
`endif

  assign a_in      = ({1'b0, addr_a} < CELLS_X);
  assign b_in      = ({1'b0, addr_b} < CELLS_X);
  // Port A is locked out while the engine owns the array, so the two write
  // sources never collide.
  assign a_wr      = we_a & a_in & ~clr_busy;
  assign eng_wdata = eng_fill ? '0 : mem[eng_raddr];

  always_ff @(posedge clk) begin
    if (eng_we) begin
      mem[eng_waddr] <= eng_wdata;
    end else if (a_wr) begin
      mem[addr_a] <= data_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
    end else if (!clr_busy) begin
      if (!a_in)     q_a <= '0;
      else if (we_a) q_a <= data_a;
      else           q_a <= mem[addr_a];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_b <= '0;
    end else begin
      if (!b_in)                         q_b <= '0;
      else if (a_wr && addr_a == addr_b) q_b <= data_a;
      else                               q_b <= mem[addr_b];
    end
  end

endmodule
